dac_spi_tx: RTL and testbench

//  Transmit end of the processor output path. Takes each 10-bit offset-binary sample from the

---
 rtl/dac_spi_tx_pkg.sv | 39 +++
 rtl/dac_spi_tx_half_period_timer.sv | 38 +++
 rtl/dac_spi_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg
//   Shared definitions for the MCP4911-class SPI DAC transmitter: FSM state
//   encoding, frame geometry, the default configuration nibble, the bit
//   positions of the MCP4911 write word, and a helper that assembles a frame.
//   No ports (package).
package dac_spi_tx_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CSHI  = 3'd4,
    ST_LDAC  = 3'd5
  } state_t;

  localparam int FRAME_W   = 16;
  localparam int DATA_W    = 10;
  localparam int BIT_CNT_W = $clog2(FRAME_W);

  // /A-B=0 (channel A), BUF=1, /GA=1 (1x gain), /SHDN=1 (output active)
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0111;

  // MCP4911 write word layout
  localparam int BIT_AB    = 15;
  localparam int BIT_BUF   = 14;
  localparam int BIT_GA    = 13;
  localparam int BIT_SHDN  = 12;
  localparam int DATA_MSB  = 11;
  localparam int DATA_LSB  = 2;

  // Config nibble on top, 10-bit sample, two don't-care LSBs driven as zero.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]        cfg,
                                                     input logic [DATA_W-1:0] data);
    return {cfg, data, 2'b00};
  endfunction

endpackage

// File: rtl/dac_spi_tx_half_period_timer.sv
// half_period_timer
//   SCK phase divider. Counts 0..CLK_DIV-1 and flags the last count of each
//   half-period, then wraps. Holding restart keeps the count at zero so the
//   first phase after release is a full half-period.
// Ports
//   sysclk   in  1  system clock
//   rst_n    in  1  asynchronous active-low reset
//   restart  in  1  hold counter at zero
//   tick     out 1  high on the final cycle of each half-period
module half_period_timer #(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  // A one-bit counter still works for CLK_DIV=1: it sits at zero and ticks
  // every cycle.
  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (restart || (count_reg == CNT_LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == CNT_LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx
//   Serialises each 10-bit offset-binary sample into a 16-bit MCP4911 write
//   frame (MSB first), then pulses LDAC. A one-deep pending buffer holds a
//   sample strobed while a frame is in flight; a second unsent sample
//   overwrites it and sets the sticky overrun flag.
// Ports
//   sysclk   in  1   system clock
//   rst_n    in  1   asynchronous active-low reset
//   pulse    in  1   sample strobe, one sample per high cycle
//   data_in  in  10  offset-binary sample, taken when pulse=1
//   dac_cs   out 1   chip select, active low
//   dac_sck  out 1   SPI clock, idles low, DAC samples on rising edge
//   dac_sdi  out 1   SPI data, MSB first
//   dac_ld   out 1   LDAC, active low
//   busy     out 1   frame in progress (SETUP..LDAC)
//   overrun  out 1   sticky: pending sample was overwritten
// All pin outputs come straight from flops.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int         CLK_DIV = 25,
  parameter logic [3:0] DAC_CFG = DAC_CFG_DEFAULT
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              pulse,
  input  logic [DATA_W-1:0] data_in,
  output logic              dac_cs,
  output logic              dac_sck,
  output logic              dac_sdi,
  output logic              dac_ld,
  output logic              busy,
  output logic              overrun
);

  state_t                 state_reg,      state_next;
  // Holds the bits still to be sent after the one currently on dac_sdi.
  logic [FRAME_W-2:0]     shift_reg,      shift_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg,    bit_cnt_next;
  logic                   pend_valid_reg, pend_valid_next;
  logic [DATA_W-1:0]      pend_data_reg,  pend_data_next;
  logic                   overrun_reg,    overrun_next;
  logic                   cs_reg,         cs_next;
  logic                   sck_reg,        sck_next;
  logic                   sdi_reg,        sdi_next;
  logic                   ld_reg,         ld_next;
  logic                   busy_reg,       busy_next;

  logic                   tick;
  logic                   timer_restart;

  logic                   launch;        // start a new frame next cycle
  logic                   take_direct;   // this strobe launches the frame itself
  logic                   consume_pend;  // pending sample launches the frame
  logic [DATA_W-1:0]      launch_data;
  logic [FRAME_W-1:0]     launch_frame;

  // Timer idles at zero so SETUP always lasts a full half-period.
  assign timer_restart = (state_reg == ST_IDLE);

  half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .restart (timer_restart),
    .tick    (tick)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      overrun_reg    <= 1'b0;
      cs_reg         <= 1'b1;
      sck_reg        <= 1'b0;
      sdi_reg        <= 1'b0;
      ld_reg         <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      overrun_reg    <= overrun_next;
      cs_reg         <= cs_next;
      sck_reg        <= sck_next;
      sdi_reg        <= sdi_next;
      ld_reg         <= ld_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    overrun_next    = overrun_reg;
    cs_next         = cs_reg;
    sck_next        = sck_reg;
    sdi_next        = sdi_reg;
    ld_next         = ld_reg;
    busy_next       = busy_reg;
    launch          = 1'b0;
    take_direct     = 1'b0;
    consume_pend    = 1'b0;
    launch_data     = data_in;
    launch_frame    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (pulse) begin
          launch      = 1'b1;
          take_direct = 1'b1;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          state_next = ST_SHIFT;
          sck_next   = 1'b1;
        end
      end

      // sck_reg doubles as the phase flag: high phase ends on a falling
      // edge where sdi advances; bit 0 has no low phase and goes to HOLD.
      ST_SHIFT: begin
        if (tick) begin
          if (sck_reg) begin
            sck_next = 1'b0;
            if (bit_cnt_reg == '0) begin
              state_next = ST_HOLD;
            end else begin
              sdi_next     = shift_reg[FRAME_W-2];
              shift_next   = {shift_reg[FRAME_W-3:0], 1'b0};
              bit_cnt_next = bit_cnt_reg - 1'b1;
            end
          end else begin
            sck_next = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          state_next = ST_CSHI;
          cs_next    = 1'b1;
        end
      end

      ST_CSHI: begin
        if (tick) begin
          state_next = ST_LDAC;
          ld_next    = 1'b0;
        end
      end

      // Leaving LDAC: a waiting sample (or one strobed right now) chains
      // straight into SETUP with no IDLE cycle in between.
      ST_LDAC: begin
        if (tick) begin
          ld_next = 1'b1;
          if (pend_valid_reg) begin
            launch          = 1'b1;
            consume_pend    = 1'b1;
            launch_data     = pend_data_reg;
            pend_valid_next = 1'b0;
          end else if (pulse) begin
            launch      = 1'b1;
            take_direct = 1'b1;
          end else begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            sdi_next   = 1'b0;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Strobe during a frame parks in the pending slot. Overwriting an unsent
    // sample is an overrun; a pending sample leaving for SETUP this very
    // cycle is not being overwritten.
    if (pulse && (state_reg != ST_IDLE) && !take_direct) begin
      if (pend_valid_reg && !consume_pend) begin
        overrun_next = 1'b1;
      end
      pend_valid_next = 1'b1;
      pend_data_next  = data_in;
    end

    if (launch) begin
      launch_frame = build_frame(DAC_CFG, launch_data);
      state_next   = ST_SETUP;
      shift_next   = launch_frame[FRAME_W-2:0];
      sdi_next     = launch_frame[FRAME_W-1];
      bit_cnt_next = BIT_CNT_W'(FRAME_W - 1);
      cs_next      = 1'b0;
      sck_next     = 1'b0;
      ld_next      = 1'b1;
      busy_next    = 1'b1;
    end
  end

  assign dac_cs  = cs_reg;
  assign dac_sck = sck_reg;
  assign dac_sdi = sdi_reg;
  assign dac_ld  = ld_reg;
  assign busy    = busy_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx
//   Bench for dac_spi_tx. dut runs at CLK_DIV=2 against a cycle-level
//   reference model of frame scheduling (busy window, pending slot,
//   overrun); dut1 runs at CLK_DIV=1. A monitor plays the DAC's shift
//   register on SCK rising edges and measures pin timing.
module tb_dac_spi_tx;

  localparam int H = 2;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pulse  = 1'b0;
  logic [9:0] data_in = '0;
  logic       dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun;
  logic       pulse1 = 1'b0;
  logic [9:0] data1  = '0;
  logic       dac_cs1, dac_sck1, dac_sdi1, dac_ld1, busy1, overrun1;

  always #5 sysclk = ~sysclk;

  dac_spi_tx #(.CLK_DIV(2)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .pulse(pulse), .data_in(data_in),
    .dac_cs(dac_cs), .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_ld(dac_ld),
    .busy(busy), .overrun(overrun)
  );

  dac_spi_tx #(.CLK_DIV(1)) dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .pulse(pulse1), .data_in(data1),
    .dac_cs(dac_cs1), .dac_sck(dac_sck1), .dac_sdi(dac_sdi1), .dac_ld(dac_ld1),
    .busy(busy1), .overrun(overrun1)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] frame_of(input logic [9:0] d);
    return {4'b0111, d, 2'b00};
  endfunction

  // ---------------- monitor (DAC side) ----------------
  wire [1:0] cs_v   = {dac_cs1,  dac_cs};
  wire [1:0] sck_v  = {dac_sck1, dac_sck};
  wire [1:0] sdi_v  = {dac_sdi1, dac_sdi};
  wire [1:0] ld_v   = {dac_ld1,  dac_ld};
  wire [1:0] busy_v = {busy1,    busy};

  logic [15:0] got0[$];
  logic [15:0] got1[$];
  logic [15:0] sh[2];
  logic prev_cs[2], prev_sck[2], prev_sdi[2], prev_ld[2], prev_busy[2];
  int nbits[2], bits_bad[2], sdi_bad[2];
  int cs_cnt[2], ld_cnt[2], busy_cnt[2];
  int last_cs_low[2], last_ld_low[2], last_busy[2], ld_gap[2];
  int cs_rise_cyc[2], last_rise[2], sck_period[2];
  int cyc = 0;

  always @(negedge sysclk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_cs[k] = 1'b1; prev_sck[k] = 1'b0; prev_sdi[k] = 1'b0;
        prev_ld[k] = 1'b1; prev_busy[k] = 1'b0;
        nbits[k] = 0; cs_cnt[k] = 0; ld_cnt[k] = 0; busy_cnt[k] = 0;
      end else begin
        if (!cs_v[k] && sck_v[k] && !prev_sck[k]) begin
          sh[k] = {sh[k][14:0], sdi_v[k]};
          nbits[k]++;
          if (sdi_v[k] !== prev_sdi[k]) sdi_bad[k]++;
          sck_period[k] = cyc - last_rise[k];
          last_rise[k]  = cyc;
        end
        if (sck_v[k] && prev_sck[k] && (sdi_v[k] !== prev_sdi[k])) sdi_bad[k]++;
        if (!cs_v[k]) cs_cnt[k]++;
        if (cs_v[k] && !prev_cs[k]) begin
          last_cs_low[k] = cs_cnt[k]; cs_cnt[k] = 0; cs_rise_cyc[k] = cyc;
          if (nbits[k] != 16) bits_bad[k]++;
          nbits[k] = 0;
          if (k == 0) got0.push_back(sh[k]); else got1.push_back(sh[k]);
        end
        if (!ld_v[k]) ld_cnt[k]++;
        if (!ld_v[k] && prev_ld[k]) ld_gap[k] = cyc - cs_rise_cyc[k];
        if (ld_v[k] && !prev_ld[k]) begin last_ld_low[k] = ld_cnt[k]; ld_cnt[k] = 0; end
        if (busy_v[k]) busy_cnt[k]++;
        if (!busy_v[k] && prev_busy[k]) begin last_busy[k] = busy_cnt[k]; busy_cnt[k] = 0; end
        prev_cs[k] = cs_v[k]; prev_sck[k] = sck_v[k]; prev_sdi[k] = sdi_v[k];
        prev_ld[k] = ld_v[k]; prev_busy[k] = busy_v[k];
      end
    end
  end

  // ---------------- reference model (dut, CLK_DIV=2) ----------------
  // A frame launched in cycle s is busy for cycles s+1..s+35H; its last
  // cycle may launch the next frame.
  int          m_t = 0;
  int          m_end = -1;
  bit          m_pv = 0;
  logic [9:0]  m_pd = '0;
  bit          m_ovr = 0;
  bit          m_busy_next = 0;
  logic [15:0] exp_q[$];
  int          busy_bad = 0;
  int          ovr_bad = 0;

  task automatic model_reset();
    m_end = -1; m_pv = 0; m_ovr = 0; m_busy_next = 0;
  endtask

  task automatic step(input logic p, input logic [9:0] d);
    @(negedge sysclk);
    if (busy !== m_busy_next) busy_bad++;
    if (overrun !== m_ovr) ovr_bad++;
    pulse = p; data_in = d;
    if (m_t > m_end) begin
      if (p) begin exp_q.push_back(frame_of(d)); m_end = m_t + 35 * H; end
    end else if (m_t == m_end) begin
      if (m_pv) begin
        exp_q.push_back(frame_of(m_pd)); m_end = m_t + 35 * H; m_pv = 0;
        if (p) begin m_pv = 1; m_pd = d; end
      end else if (p) begin
        exp_q.push_back(frame_of(d)); m_end = m_t + 35 * H;
      end
    end else if (p) begin
      if (m_pv) m_ovr = 1;
      m_pv = 1; m_pd = d;
    end
    m_busy_next = (m_end > m_t);
    m_t++;
  endtask

  task automatic drain();
    while (m_t <= m_end + 3) step(1'b0, 10'h000);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge sysclk);
    #1;
    checks++; if ({dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun} !== 6'b100100) begin
      errors++; $display("FAIL reset_dut cs/sck/sdi/ld/busy/ovr got %b want 100100",
                         {dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun}); end
    checks++; if ({dac_cs1, dac_sck1, dac_sdi1, dac_ld1, busy1, overrun1} !== 6'b100100) begin
      errors++; $display("FAIL reset_dut1 cs/sck/sdi/ld/busy/ovr got %b want 100100",
                         {dac_cs1, dac_sck1, dac_sdi1, dac_ld1, busy1, overrun1}); end
    @(negedge sysclk); rst_n = 1'b1;
    model_reset();
    $display("reset: outputs idle after reset");
  endtask

  task automatic test_single();
    int g = got0.size(); int e = exp_q.size(); int sb = sdi_bad[0]; int bb = bits_bad[0];
    busy_bad = 0; ovr_bad = 0;
    step(1'b1, 10'h2A5);
    drain();
    checks++; if (got0.size() != g + 1) begin errors++;
      $display("FAIL single_count got %0d frames want 1", got0.size() - g); end
    else begin
      checks++; if (got0[g] !== 16'h7A94) begin errors++;
        $display("FAIL single_frame got %h want 7a94", got0[g]); end
      checks++; if (got0[g] !== exp_q[e]) begin errors++;
        $display("FAIL single_model got %h want %h", got0[g], exp_q[e]); end
    end
    checks++; if (last_cs_low[0] != 33 * H) begin errors++;
      $display("FAIL single_cs_low got %0d want %0d", last_cs_low[0], 33 * H); end
    checks++; if (last_ld_low[0] != H || ld_gap[0] != H) begin errors++;
      $display("FAIL single_ld got len %0d gap %0d want %0d/%0d", last_ld_low[0], ld_gap[0], H, H); end
    checks++; if (last_busy[0] != 35 * H) begin errors++;
      $display("FAIL single_busy_len got %0d want %0d", last_busy[0], 35 * H); end
    checks++; if (busy_bad != 0 || ovr_bad != 0 || overrun !== 1'b0) begin errors++;
      $display("FAIL single_busy_ovr got busy_bad=%0d ovr_bad=%0d ovr=%b want 0/0/0", busy_bad, ovr_bad, overrun); end
    checks++; if (sdi_bad[0] != sb || bits_bad[0] != bb) begin errors++;
      $display("FAIL single_sdi_timing got sdi_bad=%0d bits_bad=%0d want 0", sdi_bad[0] - sb, bits_bad[0] - bb); end
    $display("single: frame sent, data 2a5");
  endtask

  task automatic test_back_to_back();
    int g = got0.size(); int e = exp_q.size();
    busy_bad = 0; ovr_bad = 0;
    step(1'b1, 10'h000);
    repeat (9) step(1'b0, 10'h000);
    step(1'b1, 10'h3FF);
    drain();
    checks++; if (got0.size() != g + 2 || exp_q.size() != e + 2) begin errors++;
      $display("FAIL b2b_count got %0d frames want 2", got0.size() - g); end
    else begin
      checks++; if (got0[g] !== 16'h7000 || got0[g] !== exp_q[e]) begin errors++;
        $display("FAIL b2b_frame0 got %h want 7000", got0[g]); end
      checks++; if (got0[g+1] !== 16'h7FFC || got0[g+1] !== exp_q[e+1]) begin errors++;
        $display("FAIL b2b_frame1 got %h want 7ffc", got0[g+1]); end
    end
    checks++; if (last_busy[0] != 70 * H) begin errors++;
      $display("FAIL b2b_busy_len got %0d want %0d", last_busy[0], 70 * H); end
    checks++; if (busy_bad != 0 || ovr_bad != 0) begin errors++;
      $display("FAIL b2b_model got busy_bad=%0d ovr_bad=%0d want 0", busy_bad, ovr_bad); end
    $display("back_to_back: two frames chained");
  endtask

  task automatic test_edge_strobe();
    int g = got0.size();
    logic [9:0] d1 = 10'($urandom); logic [9:0] d2 = 10'($urandom);
    busy_bad = 0; ovr_bad = 0;
    step(1'b1, d1);
    repeat (35 * H - 1) step(1'b0, 10'h000);
    step(1'b1, d2);
    drain();
    checks++; if (got0.size() != g + 2) begin errors++;
      $display("FAIL edge_count got %0d frames want 2", got0.size() - g); end
    else begin
      checks++; if (got0[g+1] !== frame_of(d2)) begin errors++;
        $display("FAIL edge_frame got %h want %h", got0[g+1], frame_of(d2)); end
    end
    checks++; if (overrun !== 1'b0 || last_busy[0] != 70 * H) begin errors++;
      $display("FAIL edge_ovr_busy got ovr=%b busy_len=%0d want 0/%0d", overrun, last_busy[0], 70 * H); end
    checks++; if (busy_bad != 0 || ovr_bad != 0) begin errors++;
      $display("FAIL edge_model got busy_bad=%0d ovr_bad=%0d want 0", busy_bad, ovr_bad); end
    $display("edge_strobe: data %h sent in next frame", d2);
  endtask

  task automatic test_overrun();
    int g = got0.size();
    busy_bad = 0; ovr_bad = 0;
    step(1'b1, 10'h111);
    repeat (19) step(1'b0, 10'h000);
    step(1'b1, 10'h222);
    repeat (19) step(1'b0, 10'h000);
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL overrun_early got %b want 0", overrun); end
    step(1'b1, 10'h333);
    step(1'b0, 10'h000);
    checks++; if (overrun !== 1'b1) begin errors++;
      $display("FAIL overrun_set got %b want 1", overrun); end
    drain();
    checks++; if (got0.size() != g + 2) begin errors++;
      $display("FAIL overrun_count got %0d frames want 2", got0.size() - g); end
    else begin
      checks++; if (got0[g] !== 16'h7444 || got0[g+1] !== 16'h7CCC) begin errors++;
        $display("FAIL overrun_frames got %h %h want 7444 7ccc", got0[g], got0[g+1]); end
    end
    checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL overrun_sticky got ovr=%b busy=%b want 1/0", overrun, busy); end
    checks++; if (busy_bad != 0 || ovr_bad != 0) begin errors++;
      $display("FAIL overrun_model got busy_bad=%0d ovr_bad=%0d want 0", busy_bad, ovr_bad); end
    $display("overrun: 222 dropped, flag sticky");
  endtask

  task automatic test_random();
    int g = got0.size(); int e = exp_q.size(); int n;
    busy_bad = 0; ovr_bad = 0;
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 39) == 0), 10'($urandom));
    drain();
    n = exp_q.size() - e;
    checks++; if (got0.size() - g != n) begin errors++;
      $display("FAIL random_count got %0d frames want %0d", got0.size() - g, n); end
    else begin
      for (int i = 0; i < n; i++) begin
        checks++; if (got0[g+i] !== exp_q[e+i]) begin errors++;
          $display("FAIL random_frame%0d got %h want %h", i, got0[g+i], exp_q[e+i]); end
      end
    end
    checks++; if (busy_bad != 0 || ovr_bad != 0) begin errors++;
      $display("FAIL random_model got busy_bad=%0d ovr_bad=%0d want 0", busy_bad, ovr_bad); end
    $display("random: %0d frames checked", n);
  endtask

  task automatic test_reset_mid_shift();
    int g; int e;
    step(1'b1, 10'($urandom));
    repeat (21) step(1'b0, 10'h000);
    @(posedge sysclk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({dac_cs, dac_sck, dac_ld, busy, overrun} !== 5'b10100) begin errors++;
      $display("FAIL midreset_pins cs/sck/ld/busy/ovr got %b want 10100",
               {dac_cs, dac_sck, dac_ld, busy, overrun}); end
    repeat (3) @(posedge sysclk);
    @(negedge sysclk); rst_n = 1'b1;
    model_reset();
    g = got0.size(); e = exp_q.size();
    busy_bad = 0; ovr_bad = 0;
    step(1'b1, 10'h155);
    drain();
    checks++; if (got0.size() != g + 1) begin errors++;
      $display("FAIL midreset_count got %0d frames want 1", got0.size() - g); end
    else begin
      checks++; if (got0[g] !== 16'h7554 || got0[g] !== exp_q[e]) begin errors++;
        $display("FAIL midreset_frame got %h want 7554", got0[g]); end
    end
    checks++; if (busy_bad != 0 || ovr_bad != 0 || last_busy[0] != 35 * H) begin errors++;
      $display("FAIL midreset_model got busy_bad=%0d ovr_bad=%0d busy_len=%0d", busy_bad, ovr_bad, last_busy[0]); end
    $display("reset_mid_shift: clean frame after reset");
  endtask

  task automatic test_clkdiv1();
    int g = got1.size(); int sb = sdi_bad[1]; int bb = bits_bad[1];
    bit done = 0;
    @(negedge sysclk); pulse1 = 1'b1; data1 = 10'h2A5;
    @(negedge sysclk); pulse1 = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge sysclk);
      if (!busy1) done = 1;
    end
    @(negedge sysclk);
    checks++; if (!done) begin errors++;
      $display("FAIL div1_timeout got busy stuck want idle within 200 cycles"); end
    checks++; if (got1.size() != g + 1) begin errors++;
      $display("FAIL div1_count got %0d frames want 1", got1.size() - g); end
    else begin
      checks++; if (got1[g] !== frame_of(10'h2A5)) begin errors++;
        $display("FAIL div1_frame got %h want %h", got1[g], frame_of(10'h2A5)); end
    end
    checks++; if (sck_period[1] != 2 || last_busy[1] != 35 || last_cs_low[1] != 33) begin errors++;
      $display("FAIL div1_timing got sck_per=%0d busy=%0d cs_low=%0d want 2/35/33",
               sck_period[1], last_busy[1], last_cs_low[1]); end
    checks++; if (sdi_bad[1] != sb || bits_bad[1] != bb || overrun1 !== 1'b0) begin errors++;
      $display("FAIL div1_sdi got sdi_bad=%0d bits_bad=%0d ovr=%b want 0/0/0",
               sdi_bad[1] - sb, bits_bad[1] - bb, overrun1); end
    $display("clkdiv1: frame sent at CLK_DIV=1");
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      sh[k] = '0; bits_bad[k] = 0; sdi_bad[k] = 0; last_cs_low[k] = 0; last_ld_low[k] = 0;
      last_busy[k] = 0; ld_gap[k] = 0; cs_rise_cyc[k] = 0; last_rise[k] = 0; sck_period[k] = 0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_edge_strobe();
    test_overrun();
    test_random();
    test_reset_mid_shift();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
